// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_REL = 2'd2
  } irq_state_t;

  localparam logic [63:0] DEFAULT_MASK_ADDR = 64'h800;

endpackage

// File: rtl/irq_edge_det.sv
// Two-flop synchronizer for one raw interrupt line followed by a rising-edge
// detector that compares the second and third flop stages.
module irq_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic src,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic sync3;

  // Shift the raw line through the synchronizer and the edge-history flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= src;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise = sync2 & ~sync3;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: per-source edge capture into a pending register, a
// snooped memory-mapped mask register, a fixed-priority encoder (index 0
// highest) and a request/acknowledge handshake FSM towards the processor.
module irq_controller
  import irq_pkg::*;
#(
  parameter int            N         = 64,
  parameter int            NSRC      = 4,
  parameter logic [N-1:0]  MASK_ADDR = N'(DEFAULT_MASK_ADDR)
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic [NSRC-1:0]         irq_src,
  input  logic                    ExtlAck,
  input  logic [N-1:0]            DM_addr,
  input  logic [N-1:0]            DM_writeData,
  input  logic                    DM_writeEnable,
  output logic                    ExtIRQ,
  output logic [$clog2(NSRC)-1:0] irq_id,
  output logic [NSRC-1:0]         pending,
  output logic [NSRC-1:0]         mask
);

  localparam int IDW = $clog2(NSRC);

  irq_state_t      state;
  irq_state_t      state_next;
  logic [IDW-1:0]  id_next;
  logic [IDW-1:0]  grant_id;
  logic [NSRC-1:0] rise_vec;
  logic [NSRC-1:0] req_vec;
  logic [NSRC-1:0] clear_vec;
  logic            mask_write;
  logic            unused_write_bits;

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    irq_edge_det u_det (
      .clk   (CLOCK_50),
      .reset (reset),
      .src   (irq_src[g]),
      .rise  (rise_vec[g])
    );
  end

  // Only the low NSRC data bits feed the mask; the rest of the bus is ignored.
  assign unused_write_bits = ^DM_writeData[N-1:NSRC];
  assign mask_write        = DM_writeEnable && (DM_addr == MASK_ADDR);

  // Pick the lowest-numbered enabled pending source.
  always_comb begin
    req_vec  = pending & mask;
    grant_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req_vec[i]) grant_id = IDW'(i);
    end
  end

  // Next-state logic for the grant/acknowledge handshake.
  always_comb begin
    state_next = state;
    id_next    = irq_id;
    clear_vec  = '0;
    case (state)
      IDLE: begin
        if (|req_vec) begin
          state_next = REQ;
          id_next    = grant_id;
        end
      end
      REQ: begin
        if (ExtlAck) begin
          state_next = WAIT_REL;
          clear_vec  = NSRC'(1) << irq_id;
        end
      end
      WAIT_REL: begin
        if (!ExtlAck) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and in-service index registers; the index holds until the next grant.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state  <= IDLE;
      irq_id <= '0;
    end else begin
      state  <= state_next;
      irq_id <= id_next;
    end
  end

  // Pending bits: a fresh edge wins over a same-cycle acknowledge clear.
  always_ff @(posedge CLOCK_50) begin
    if (reset) pending <= '0;
    else       pending <= (pending & ~clear_vec) | rise_vec;
  end

  // Mask register loaded by snooping writes to its address.
  always_ff @(posedge CLOCK_50) begin
    if (reset)           mask <= '1;
    else if (mask_write) mask <= DM_writeData[NSRC-1:0];
  end

  assign ExtIRQ = (state == REQ);

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: a reset-to-grant vector table,
// directed multi-cycle sequences and a randomized run against a reference model.
module tb_irq_controller;

  logic        CLOCK_50 = 1'b0;
  logic        reset    = 1'b1;
  logic [3:0]  irq_src  = '0;
  logic        ExtlAck  = 1'b0;
  logic [63:0] DM_addr  = '0;
  logic [63:0] DM_writeData = '0;
  logic        DM_writeEnable = 1'b0;
  logic        ExtIRQ;
  logic [1:0]  irq_id;
  logic [3:0]  pending;
  logic [3:0]  mask;

  int checks   = 0;
  int failures = 0;

  irq_controller dut (
    .CLOCK_50       (CLOCK_50),
    .reset          (reset),
    .irq_src        (irq_src),
    .ExtlAck        (ExtlAck),
    .DM_addr        (DM_addr),
    .DM_writeData   (DM_writeData),
    .DM_writeEnable (DM_writeEnable),
    .ExtIRQ         (ExtIRQ),
    .irq_id         (irq_id),
    .pending        (pending),
    .mask           (mask)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Reference model. srcHist[0] is the line value sampled at the previous edge,
  // srcHist[1] two edges back, srcHist[2] three edges back. A source becomes
  // pending at the edge where its sample from two edges back shows a 0->1 step.
  // phase: 0 = waiting for work, 1 = requesting, 2 = waiting for ack release.
  logic [3:0] srcHist [3];
  int         mPhase = 0;
  logic [1:0] mId    = '0;
  logic [3:0] mPend  = '0;
  logic [3:0] mMask  = 4'hF;

  task automatic modelStep();
    logic [3:0] setBits;
    logic [3:0] clrBits;
    if (reset) begin
      for (int i = 0; i < 3; i++) srcHist[i] = '0;
      mPhase = 0;
      mId    = '0;
      mPend  = '0;
      mMask  = 4'hF;
    end else begin
      setBits = srcHist[1] & ~srcHist[2];
      clrBits = '0;
      if (mPhase == 1 && ExtlAck) begin
        clrBits[mId] = 1'b1;
        mPhase = 2;
      end else if (mPhase == 2 && !ExtlAck) begin
        mPhase = 0;
      end else if (mPhase == 0 && (mPend & mMask) != 0) begin
        for (int i = 3; i >= 0; i--) if (mPend[i] && mMask[i]) mId = 2'(i);
        mPhase = 1;
      end
      if (DM_writeEnable && DM_addr == 64'h800) mMask = DM_writeData[3:0];
      mPend = (mPend & ~clrBits) | setBits;
      srcHist[2] = srcHist[1];
      srcHist[1] = srcHist[0];
      srcHist[0] = irq_src;
    end
  endtask

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkValue("model_ExtIRQ",  64'(ExtIRQ),  64'(mPhase == 1));
    checkValue("model_irq_id",  64'(irq_id),  64'(mId));
    checkValue("model_pending", 64'(pending), 64'(mPend));
    checkValue("model_mask",    64'(mask),    64'(mMask));
  endtask

  // Drive one cycle of inputs (called at a falling edge), clock it, compare.
  task automatic applyStimulus(input logic rst, input logic [3:0] src, input logic ack,
                               input logic we, input logic [63:0] addr, input logic [63:0] data);
    reset          = rst;
    irq_src        = src;
    ExtlAck        = ack;
    DM_writeEnable = we;
    DM_addr        = addr;
    DM_writeData   = data;
    @(posedge CLOCK_50);
    modelStep();
    @(negedge CLOCK_50);
    checkOutput();
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 64'h0, 64'h0);
  endtask

  task automatic pulse(input logic [3:0] src);
    applyStimulus(1'b0, src, 1'b0, 1'b0, 64'h0, 64'h0);
  endtask

  task automatic ackRelease();
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0, 64'h0, 64'h0);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 64'h0, 64'h0);
  endtask

  task automatic writeMask(input logic [63:0] addr, input logic [63:0] data);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, addr, data);
  endtask

  // Idle until ExtIRQ is seen, within a fixed cycle budget.
  task automatic waitIrq(input string name);
    bit got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      if (ExtIRQ) got = 1'b1;
      else idle();
    end
    checks++;
    if (!got) begin
      failures++;
      $display("[TB] FAIL %s ExtIRQ actual=0 required=1 within 12 cycles", name);
    end
  endtask

  typedef struct {
    logic [3:0] src;
    logic       ack;
    logic       expIrq;
    logic [1:0] expId;
    logic [3:0] expPend;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [3:0] rSrc;
    logic       rAck;
    tbl[0] = '{4'b0100, 1'b0, 1'b0, 2'd0, 4'b0000};
    tbl[1] = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000};
    tbl[2] = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0100};
    tbl[3] = '{4'b0000, 1'b0, 1'b1, 2'd2, 4'b0100};
    tbl[4] = '{4'b0000, 1'b0, 1'b1, 2'd2, 4'b0100};
    tbl[5] = '{4'b0000, 1'b0, 1'b1, 2'd2, 4'b0100};
    tbl[6] = '{4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000};
    tbl[7] = '{4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000};
    tbl[8] = '{4'b0000, 1'b0, 1'b0, 2'd2, 4'b0000};
    tbl[9] = '{4'b0000, 1'b0, 1'b0, 2'd2, 4'b0000};

    @(negedge CLOCK_50);
    applyStimulus(1'b1, 4'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    applyStimulus(1'b1, 4'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    checkValue("reset_ExtIRQ",  64'(ExtIRQ),  64'h0);
    checkValue("reset_irq_id",  64'(irq_id),  64'h0);
    checkValue("reset_pending", 64'(pending), 64'h0);
    checkValue("reset_mask",    64'(mask),    64'hF);

    $display("[TB] single pulse on source 2");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, tbl[i].src, tbl[i].ack, 1'b0, 64'h0, 64'h0);
      checkValue($sformatf("tbl%0d_ExtIRQ", i),  64'(ExtIRQ),  64'(tbl[i].expIrq));
      checkValue($sformatf("tbl%0d_irq_id", i),  64'(irq_id),  64'(tbl[i].expId));
      checkValue($sformatf("tbl%0d_pending", i), 64'(pending), 64'(tbl[i].expPend));
    end

    $display("[TB] simultaneous sources 3 and 1");
    pulse(4'b1010);
    waitIrq("prio_first");
    checkValue("prio_first_id", 64'(irq_id), 64'd1);
    idle(); idle();
    ackRelease();
    waitIrq("prio_second");
    checkValue("prio_second_id", 64'(irq_id), 64'd3);
    idle(); idle();
    ackRelease();
    idle();
    checkValue("prio_pending_empty", 64'(pending), 64'h0);

    $display("[TB] masking");
    writeMask(64'h808, 64'h0);
    checkValue("mask_wrong_addr", 64'(mask), 64'hF);
    writeMask(64'h800, 64'h0);
    checkValue("mask_cleared", 64'(mask), 64'h0);
    pulse(4'b0001);
    for (int i = 0; i < 5; i++) idle();
    checkValue("masked_pending", 64'(pending), 64'h1);
    checkValue("masked_no_irq",  64'(ExtIRQ),  64'h0);
    writeMask(64'h800, 64'hF);
    waitIrq("unmask_grant");
    checkValue("unmask_id", 64'(irq_id), 64'd0);
    ackRelease();

    $display("[TB] new edge in the clear cycle");
    pulse(4'b0001);
    waitIrq("clear_race_first");
    pulse(4'b0001);
    idle();
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0, 64'h0, 64'h0);
    checkValue("clear_race_pending", 64'(pending), 64'h1);
    checkValue("clear_race_no_irq",  64'(ExtIRQ),  64'h0);
    idle();
    waitIrq("clear_race_regrant");
    checkValue("clear_race_id", 64'(irq_id), 64'd0);
    ackRelease();
    checkValue("clear_race_done", 64'(pending), 64'h0);

    $display("[TB] ack held high");
    pulse(4'b0100);
    waitIrq("hold_first");
    applyStimulus(1'b0, 4'b0100, 1'b1, 1'b0, 64'h0, 64'h0);
    checkValue("hold_irq_0", 64'(ExtIRQ), 64'h0);
    for (int i = 1; i < 5; i++) begin
      applyStimulus(1'b0, 4'h0, 1'b1, 1'b0, 64'h0, 64'h0);
      checkValue($sformatf("hold_irq_%0d", i), 64'(ExtIRQ), 64'h0);
    end
    checkValue("hold_pending", 64'(pending), 64'h4);
    idle();
    waitIrq("hold_regrant");
    checkValue("hold_id", 64'(irq_id), 64'd2);
    ackRelease();

    $display("[TB] reset during request");
    writeMask(64'h800, 64'h6);
    pulse(4'b1010);
    waitIrq("reset_mid_req");
    checkValue("reset_mid_pending_before", 64'(pending), 64'hA);
    applyStimulus(1'b1, 4'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    checkValue("reset_mid_ExtIRQ",  64'(ExtIRQ),  64'h0);
    checkValue("reset_mid_pending", 64'(pending), 64'h0);
    checkValue("reset_mid_mask",    64'(mask),    64'hF);
    applyStimulus(1'b1, 4'b0001, 1'b0, 1'b0, 64'h0, 64'h0);
    pulse(4'b0001);
    waitIrq("held_through_reset");
    checkValue("held_through_reset_id", 64'(irq_id), 64'd0);
    ackRelease();

    $display("[TB] randomized run");
    rSrc = '0;
    rAck = 1'b0;
    for (int i = 0; i < 800; i++) begin
      rSrc = rSrc ^ (4'($urandom) & 4'($urandom));
      if ($urandom_range(0, 2) == 0) rAck = ~rAck;
      applyStimulus(($urandom_range(0, 99) == 0), rSrc, rAck,
                    ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 3) == 0) ? 64'h808 : 64'h800,
                    64'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
